// File: rtl/clockworks_hex_if.sv
// Display bus between the SOC core and the board hex digit.
//   bitin              value to show; only the low nibble reaches the digit
//   a_output..g_output 7-segment drives, active-low (0 = segment lit)
// The master modport is the core side (drives bitin) and the slave modport
// is the decoder side (drives the segments).
interface clockworks_hex_if;
    logic [31:0] bitin;
    logic        a_output;
    logic        b_output;
    logic        c_output;
    logic        d_output;
    logic        e_output;
    logic        f_output;
    logic        g_output;

    modport master (
        output bitin,
        input  a_output, b_output, c_output, d_output, e_output, f_output, g_output
    );

    modport slave (
        input  bitin,
        output a_output, b_output, c_output, d_output, e_output, f_output, g_output
    );
endinterface

// File: rtl/clockworks_hex.sv
// Board-support block: clock gearbox, reset conditioner and hex digit decoder.
//   CLK     board clock, the only clock for every register here
//   RESET   synchronous active-high button reset
//   bus     display bus (slave side): bitin in, segments a..g out (active-low)
//   clk     core clock = CLK / 2^(SLOW+1), 50% duty, low during/after reset
//   resetn  core reset, active-low; released once a full clk period has run
module clockworks_hex #(
    parameter int SLOW = 21
) (
    input  logic              CLK,
    input  logic              RESET,
    clockworks_hex_if.slave   bus,
    output logic              clk,
    output logic              resetn
);

    localparam logic [SLOW:0] CNT_ONE = {{SLOW{1'b0}}, 1'b1};

    logic [SLOW:0] cnt;
    logic          rdy;

    // Free-running divider. rdy sets on the all-ones -> 0 wrap, so the core
    // has seen exactly one full clk period (including a rising edge) in reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
            rdy <= 1'b0;
        end else begin
            cnt <= cnt + CNT_ONE;
            if (&cnt) begin
                rdy <= 1'b1;
            end
        end
    end

    // Taken straight from a flop so the core clock never glitches.
    assign clk    = cnt[SLOW];
    assign resetn = rdy;

    // Hex decoder: segs is {a,b,c,d,e,f,g}, active-low.
    logic [6:0] segs;

    always_comb begin
        segs = 7'b1111111;
        case (bus.bitin[3:0])
            4'h0: segs = 7'b0000001;
            4'h1: segs = 7'b1001111;
            4'h2: segs = 7'b0010010;
            4'h3: segs = 7'b0000110;
            4'h4: segs = 7'b1001100;
            4'h5: segs = 7'b0100100;
            4'h6: segs = 7'b0100000;
            4'h7: segs = 7'b0001111;
            4'h8: segs = 7'b0000000;
            4'h9: segs = 7'b0000100;
            4'hA: segs = 7'b0001000;
            4'hB: segs = 7'b1100000;
            4'hC: segs = 7'b0110001;
            4'hD: segs = 7'b1000010;
            4'hE: segs = 7'b0110000;
            4'hF: segs = 7'b0111000;
            default: segs = 7'b1111111;
        endcase
    end

    assign bus.a_output = segs[6];
    assign bus.b_output = segs[5];
    assign bus.c_output = segs[4];
    assign bus.d_output = segs[3];
    assign bus.e_output = segs[2];
    assign bus.f_output = segs[1];
    assign bus.g_output = segs[0];

    // Upper bits of the displayed value have no effect on the digit.
    logic unused_upper_bits;
    assign unused_upper_bits = ^bus.bitin[31:4];

endmodule

// File: tb/tb_clockworks_hex.sv
// Bench for clockworks_hex: a SLOW=2 instance for gearbox/reset timing and the
// decoder, plus a default-SLOW instance for the divider width.
module tb_clockworks_hex;

    logic CLK;
    logic RESET;
    logic clk_s;
    logic resetn_s;
    logic clk_d;
    logic resetn_d;

    int checks;
    int failures;

    clockworks_hex_if bus_s ();
    clockworks_hex_if bus_d ();

    clockworks_hex #(.SLOW(2)) u_dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .bus    (bus_s.slave),
        .clk    (clk_s),
        .resetn (resetn_s)
    );

    clockworks_hex u_dut_def (
        .CLK    (CLK),
        .RESET  (RESET),
        .bus    (bus_d.slave),
        .clk    (clk_d),
        .resetn (resetn_d)
    );

    logic [6:0] seg_s;
    logic [6:0] seg_d;
    assign seg_s = {bus_s.a_output, bus_s.b_output, bus_s.c_output, bus_s.d_output,
                    bus_s.e_output, bus_s.f_output, bus_s.g_output};
    assign seg_d = {bus_d.a_output, bus_d.b_output, bus_d.c_output, bus_d.d_output,
                    bus_d.e_output, bus_d.f_output, bus_d.g_output};

    // Lit segments per nibble, {a..g}, 1 = lit; outputs are the inverse.
    localparam logic [6:0] LIT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Clock / reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One CLK edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (clk_s !== 1'b0) begin
                failures++;
                $display("FAIL reset_clk cycle=%0d got=%b want=0", i, clk_s);
            end
            checks++;
            if (resetn_s !== 1'b0) begin
                failures++;
                $display("FAIL reset_resetn cycle=%0d got=%b want=0", i, resetn_s);
            end
        end
    endtask

    task automatic test_release();
        logic exp_clk;
        logic exp_rn;
        RESET = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            exp_clk = ((i % 8) >= 4);
            exp_rn  = (i >= 8);
            checks++;
            if (clk_s !== exp_clk) begin
                failures++;
                $display("FAIL release_clk edge=%0d got=%b want=%b", i, clk_s, exp_clk);
            end
            checks++;
            if (resetn_s !== exp_rn) begin
                failures++;
                $display("FAIL release_resetn edge=%0d got=%b want=%b", i, resetn_s, exp_rn);
            end
        end
    endtask

    task automatic test_midrun_reset();
        logic exp_clk;
        logic exp_rn;
        // Counter is at 0 after the release run; 4 more edges puts clk high.
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (clk_s !== 1'b1 || resetn_s !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre got clk=%b resetn=%b want clk=1 resetn=1", clk_s, resetn_s);
        end
        RESET = 1'b1;
        tick();
        checks++;
        if (clk_s !== 1'b0 || resetn_s !== 1'b0) begin
            failures++;
            $display("FAIL midrun_pulse got clk=%b resetn=%b want clk=0 resetn=0", clk_s, resetn_s);
        end
        RESET = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_clk = ((i % 8) >= 4);
            exp_rn  = (i >= 8);
            checks++;
            if (clk_s !== exp_clk || resetn_s !== exp_rn) begin
                failures++;
                $display("FAIL midrun_recover edge=%0d got clk=%b resetn=%b want clk=%b resetn=%b",
                         i, clk_s, resetn_s, exp_clk, exp_rn);
            end
        end
    endtask

    task automatic test_hex_sweep();
        logic [6:0] exp;
        for (int n = 0; n < 16; n++) begin
            bus_s.bitin = {$urandom_range(0, 32'h0FFF_FFFF)} << 4 | 32'(n);
            #1;
            exp = ~LIT[n];
            checks++;
            if (seg_s !== exp) begin
                failures++;
                $display("FAIL hex_sweep nibble=%h bitin=%h got=%b want=%b",
                         n, bus_s.bitin, seg_s, exp);
            end
        end
        // Spot values written out directly.
        bus_s.bitin = 32'h0; #1;
        checks++;
        if (seg_s !== 7'b0000001) begin
            failures++;
            $display("FAIL hex_0 got=%b want=0000001", seg_s);
        end
        bus_s.bitin = 32'hA; #1;
        checks++;
        if (seg_s !== 7'b0001000) begin
            failures++;
            $display("FAIL hex_A got=%b want=0001000", seg_s);
        end
        bus_s.bitin = 32'hF; #1;
        checks++;
        if (seg_s !== 7'b0111000) begin
            failures++;
            $display("FAIL hex_F got=%b want=0111000", seg_s);
        end
    endtask

    task automatic test_upper_ignored();
        logic [6:0] seg_hi;
        bus_s.bitin = 32'hFFFF_FFF3; #1;
        seg_hi = seg_s;
        checks++;
        if (seg_hi !== 7'b0000110) begin
            failures++;
            $display("FAIL upper_hi got=%b want=0000110", seg_hi);
        end
        bus_s.bitin = 32'h0000_0003; #1;
        checks++;
        if (seg_s !== 7'b0000110 || seg_s !== seg_hi) begin
            failures++;
            $display("FAIL upper_lo got=%b want=0000110 (hi gave %b)", seg_s, seg_hi);
        end
        // Decoder is unaffected by reset.
        RESET = 1'b1;
        bus_s.bitin = 32'h8;
        tick();
        checks++;
        if (seg_s !== 7'b0000000) begin
            failures++;
            $display("FAIL hex_in_reset got=%b want=0000000", seg_s);
        end
        RESET = 1'b0;
    endtask

    task automatic test_default_slow();
        checks++;
        if ($bits(u_dut_def.cnt) !== 22) begin
            failures++;
            $display("FAIL default_cnt_width got=%0d want=22", $bits(u_dut_def.cnt));
        end
        checks++;
        if ((64'd1 << $bits(u_dut_def.cnt)) !== 64'd4194304) begin
            failures++;
            $display("FAIL default_period got=%0d want=4194304", 64'd1 << $bits(u_dut_def.cnt));
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        checks++;
        if (u_dut_def.cnt !== 22'd100) begin
            failures++;
            $display("FAIL default_cnt got=%0d want=100", u_dut_def.cnt);
        end
        checks++;
        if (clk_d !== 1'b0 || resetn_d !== 1'b0) begin
            failures++;
            $display("FAIL default_outputs got clk=%b resetn=%b want clk=0 resetn=0", clk_d, resetn_d);
        end
        bus_d.bitin = 32'h1234_567D; #1;
        checks++;
        if (seg_d !== 7'b1000010) begin
            failures++;
            $display("FAIL default_hex got=%b want=1000010", seg_d);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        RESET       = 1'b1;
        bus_s.bitin = 32'h0;
        bus_d.bitin = 32'h0;
        test_reset();
        test_release();
        test_midrun_reset();
        test_hex_sweep();
        test_upper_ignored();
        test_default_slow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
